// File: rtl/question_index_scheduler.sv
// question_index_scheduler
// Chooses a question index for each quiz round and never repeats one until the
// next clear. A candidate comes from a free-running LFSR. A used-mask is then
// probed linearly from that candidate until a free slot turns up.
// The design raises exhausted once every slot has been handed out.
module question_index_scheduler #(
    parameter int                N_QUESTIONS = 16,
    parameter int                IDX_W       = 4,
    parameter int                LFSR_W      = 8,
    parameter logic [LFSR_W-1:0] SEED        = 8'hA5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             request,
    output logic [IDX_W-1:0] index,
    output logic             ready,
    output logic             busy,
    output logic             exhausted,
    output logic [IDX_W:0]   used_count,
    output logic [2:0]       db_estado
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SAMPLE = 3'd1,
        S_PROBE  = 3'd2,
        S_DONE   = 3'd3,
        S_EXH    = 3'd4
    } state_t;

    // The 8-bit taps implement x^8+x^6+x^5+x^4+1. Other widths fall back to
    // x^W+x^(W-1)+1: the two repeated taps cancel in the XOR.
    localparam int TAP_A = LFSR_W - 1;
    localparam int TAP_B = (LFSR_W == 8) ? 5 : LFSR_W - 2;
    localparam int TAP_C = (LFSR_W == 8) ? 4 : LFSR_W - 2;
    localparam int TAP_D = (LFSR_W == 8) ? 3 : LFSR_W - 2;

    localparam logic [IDX_W:0]   NQ       = (IDX_W+1)'(N_QUESTIONS);
    localparam logic [IDX_W-1:0] LAST     = IDX_W'(N_QUESTIONS - 1);
    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] CAND_ONE = IDX_W'(1);

    state_t                 r_state;
    state_t                 w_next;
    logic [LFSR_W-1:0]      r_lfsr;
    logic [IDX_W-1:0]       r_cand;
    logic [N_QUESTIONS-1:0] r_used;
    logic [IDX_W-1:0]       r_index;
    logic [IDX_W:0]         r_count;

    logic                   w_fb;
    logic [IDX_W-1:0]       w_raw;
    logic [IDX_W-1:0]       w_sample;
    logic                   w_hit;

    assign w_fb     = r_lfsr[TAP_A] ^ r_lfsr[TAP_B] ^ r_lfsr[TAP_C] ^ r_lfsr[TAP_D];
    assign w_raw    = r_lfsr[IDX_W-1:0];
    // A raw value outside the question range folds onto slot 0. Probing then
    // starts from slot 0.
    assign w_sample = ({1'b0, w_raw} >= NQ) ? '0 : w_raw;
    assign w_hit    = ~r_used[r_cand];

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic and status outputs. Clear overrides every other transition.
    always_comb begin
        w_next    = r_state;
        ready     = 1'b0;
        busy      = 1'b0;
        exhausted = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                ready = (r_state == S_DONE);
                if (request) w_next = (r_count == NQ) ? S_EXH : S_SAMPLE;
            end
            S_SAMPLE: begin
                busy   = 1'b1;
                w_next = S_PROBE;
            end
            S_PROBE: begin
                busy = 1'b1;
                if (w_hit) w_next = S_DONE;
            end
            S_EXH:   exhausted = 1'b1;
            default: w_next = S_IDLE;
        endcase
        if (clear) w_next = S_IDLE;
    end

    // Free-running LFSR. It is not affected by clear or by the FSM state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_lfsr <= SEED;
        else       r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
    end

    // Probe pointer. It is loaded in SAMPLE and advanced on each PROBE miss,
    // and is always written before it is read, so it has no reset.
    always_ff @(posedge clock) begin
        if (r_state == S_SAMPLE)
            r_cand <= w_sample;
        else if (r_state == S_PROBE && !w_hit)
            r_cand <= (r_cand == LAST) ? '0 : r_cand + CAND_ONE;
    end

    // Used mask, committed index and hand-out count. A hit commits all three
    // together, so reset or clear can never leave a partial commit behind.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_used  <= '0;
            r_index <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_used  <= '0;
            r_index <= '0;
            r_count <= '0;
        end else if (r_state == S_PROBE && w_hit) begin
            r_used[r_cand] <= 1'b1;
            r_index        <= r_cand;
            r_count        <= r_count + CNT_ONE;
        end
    end

    assign index      = r_index;
    assign used_count = r_count;
    assign db_estado  = r_state;

endmodule
